fv_bank_req_arbiter: RTL and testbench

Shares one big feature-value SRAM bank controller's request port among N_RD Edge-PE read requesters and one output-buffer write-back requester.
- Sequences whole transactions: a read occupies the bank until the bank signals read end-of-stream; a write occupies it until the write-back burst's last beat.
- Holds the request fields stable for the bank while it is busy.
- Sits between the Edge PE array / output buffer and the bank controller's Req2Output_SRAM_Bank input. Active only in the aggregation phase (bank_agg_mode=1).

---
 rtl/fv_arb_pkg.sv | 27 ++
 rtl/fv_bank_req_arbiter_rr_pick.sv | 47 ++++
 rtl/fv_bank_req_arbiter.sv | 166 ++++++++++++++++
 tb/tb_fv_bank_req_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fv_arb_pkg.sv
// Shared types and defaults for the feature-value bank request arbiter.
//   arb_state_e   : transaction sequencer states
//   fv_req_pkt_t  : flattened request bundle, laid out like Req2Output_SRAM_Bank
//   FV_NODE_W / FV_DATA_W / FV_TAG_W : default field widths
package fv_arb_pkg;

    localparam int FV_NODE_W = 10;
    localparam int FV_DATA_W = 128;
    localparam int FV_TAG_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_BURST = 2'd1,
        ST_RD_WAIT  = 2'd2
    } arb_state_e;

    // Field order matches the bank controller's request input.
    typedef struct packed {
        logic                 valid;
        logic                 rd_wr;
        logic [FV_NODE_W-1:0] node_id;
        logic [FV_DATA_W-1:0] data;
        logic                 wr_eos;
        logic [FV_TAG_W-1:0]  pe_tag;
    } fv_req_pkt_t;

endpackage

// File: rtl/fv_bank_req_arbiter_rr_pick.sv
// Round-robin one-hot picker.
//   req : request vector
//   ptr : highest-priority index this cycle (must be < N)
//   gnt : one-hot grant of the first request at or after ptr, circular
//   idx : binary index of the granted request
//   any : at least one request present
module rr_pick
    import fv_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // rot_req[k] is the request k positions after ptr, so a plain
    // lowest-index search over rot_req gives the round-robin winner.
    logic [N-1:0] rot_req;
    logic         found;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            assign rot_req[gi] = req[(int'(ptr) + gi) % N];
        end
    endgenerate

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot_req[k]) begin
                found = 1'b1;
                idx   = IDX_W'((int'(ptr) + k) % N);
            end
        end
        gnt[idx] = found;
    end

    assign any = |req;

endmodule

// File: rtl/fv_bank_req_arbiter.sv
// Arbitrates the FV SRAM bank request port between N_RD Edge-PE readers and
// the output-buffer write-back stream, one whole transaction at a time.
//   clk, reset         : clock, synchronous active-high reset
//   bank_agg_mode      : arbitration enabled only when 1
//   rd_req/rd_node_id  : per-PE read requests (level) and node ids
//   rd_gnt             : one-hot single-cycle grant pulse
//   wb_valid/node/data/eos, wb_ready : write-back beat stream
//   bank_rd_eos        : bank's read end-of-stream
//   out_*              : request packet driven into the bank controller
//   busy               : a transaction is in flight
module fv_bank_req_arbiter
    import fv_arb_pkg::*;
#(
    parameter int N_RD         = 4,
    parameter int NODE_W       = FV_NODE_W,
    parameter int DATA_W       = FV_DATA_W,
    parameter int STARVE_LIMIT = 4,
    parameter int TAG_W        = (N_RD > 1) ? $clog2(N_RD) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     bank_agg_mode,
    input  logic [N_RD-1:0]          rd_req,
    input  logic [N_RD*NODE_W-1:0]   rd_node_id,
    output logic [N_RD-1:0]          rd_gnt,
    input  logic                     wb_valid,
    input  logic [NODE_W-1:0]        wb_node_id,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     wb_eos,
    output logic                     wb_ready,
    input  logic                     bank_rd_eos,
    output logic                     out_valid,
    output logic                     out_rd_wr,
    output logic [NODE_W-1:0]        out_node_id,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_wr_eos,
    output logic [TAG_W-1:0]         out_pe_tag,
    output logic                     busy
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e        state_reg, state_next;
    logic [TAG_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [SC_W-1:0]   starve_cnt_reg, starve_cnt_next;
    logic [NODE_W-1:0] node_reg, node_next;
    logic [TAG_W-1:0]  tag_reg, tag_next;

    logic [N_RD-1:0]   pick_gnt;
    logic [TAG_W-1:0]  pick_idx;
    logic              any_rd;
    logic              wr_win;

    rr_pick #(
        .N     (N_RD),
        .IDX_W (TAG_W)
    ) u_rr_pick (
        .req (rd_req),
        .ptr (rr_ptr_reg),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (any_rd)
    );

    // A waiting read may be passed over by at most STARVE_LIMIT write grants.
    assign wr_win = wb_valid && (!any_rd || (starve_cnt_reg < SC_W'(STARVE_LIMIT)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            rr_ptr_reg     <= '0;
            starve_cnt_reg <= '0;
            node_reg       <= '0;
            tag_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            starve_cnt_reg <= starve_cnt_next;
            node_reg       <= node_next;
            tag_reg        <= tag_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        starve_cnt_next = starve_cnt_reg;
        node_next       = node_reg;
        tag_next        = tag_reg;
        rd_gnt          = '0;
        wb_ready        = 1'b0;
        out_valid       = 1'b0;
        out_rd_wr       = 1'b0;
        out_node_id     = '0;
        out_data        = '0;
        out_wr_eos      = 1'b0;
        out_pe_tag      = '0;
        busy            = (state_reg != ST_IDLE);

        case (state_reg)
            ST_IDLE: begin
                if (bank_agg_mode) begin
                    if (wr_win) begin
                        out_valid   = 1'b1;
                        out_rd_wr   = 1'b1;
                        out_node_id = wb_node_id;
                        out_data    = wb_data;
                        out_wr_eos  = wb_eos;
                        wb_ready    = 1'b1;
                        state_next  = wb_eos ? ST_IDLE : ST_WR_BURST;
                        if (!any_rd)
                            starve_cnt_next = '0;
                        else if (starve_cnt_reg < SC_W'(STARVE_LIMIT))
                            starve_cnt_next = starve_cnt_reg + 1'b1;
                    end else if (any_rd) begin
                        rd_gnt          = pick_gnt;
                        out_valid       = 1'b1;
                        out_node_id     = rd_node_id[int'(pick_idx)*NODE_W +: NODE_W];
                        out_pe_tag      = pick_idx;
                        node_next       = rd_node_id[int'(pick_idx)*NODE_W +: NODE_W];
                        tag_next        = pick_idx;
                        rr_ptr_next     = (int'(pick_idx) == N_RD - 1) ? '0 : pick_idx + 1'b1;
                        starve_cnt_next = '0;
                        state_next      = ST_RD_WAIT;
                    end
                end
            end
            ST_WR_BURST: begin
                out_valid   = wb_valid;
                out_rd_wr   = 1'b1;
                out_node_id = wb_node_id;
                out_data    = wb_data;
                out_wr_eos  = wb_eos;
                wb_ready    = 1'b1;
                if (wb_valid && wb_eos)
                    state_next = ST_IDLE;
            end
            ST_RD_WAIT: begin
                // The bank keeps indexing lines from node id for the whole read.
                out_node_id = node_reg;
                out_pe_tag  = tag_reg;
                if (bank_rd_eos)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // Nothing is presented to the bank or the requesters while in reset.
        if (reset) begin
            rd_gnt      = '0;
            wb_ready    = 1'b0;
            out_valid   = 1'b0;
            out_rd_wr   = 1'b0;
            out_node_id = '0;
            out_data    = '0;
            out_wr_eos  = 1'b0;
            out_pe_tag  = '0;
            busy        = 1'b0;
        end
    end

    // Write-back beats inside a burst must be contiguous.
    a_wb_contiguous: assert property (@(posedge clk) disable iff (reset)
        (state_reg == ST_WR_BURST) |-> wb_valid);

endmodule

// File: tb/tb_fv_bank_req_arbiter.sv
module tb_fv_bank_req_arbiter;

    localparam int N_RD         = 4;
    localparam int NODE_W       = 10;
    localparam int DATA_W       = 128;
    localparam int STARVE_LIMIT = 4;
    localparam int TAG_W        = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   bank_agg_mode;
    logic [N_RD-1:0]        rd_req;
    logic [N_RD*NODE_W-1:0] rd_node_id;
    logic [N_RD-1:0]        rd_gnt;
    logic                   wb_valid;
    logic [NODE_W-1:0]      wb_node_id;
    logic [DATA_W-1:0]      wb_data;
    logic                   wb_eos;
    logic                   wb_ready;
    logic                   bank_rd_eos;
    logic                   out_valid;
    logic                   out_rd_wr;
    logic [NODE_W-1:0]      out_node_id;
    logic [DATA_W-1:0]      out_data;
    logic                   out_wr_eos;
    logic [TAG_W-1:0]       out_pe_tag;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    fv_bank_req_arbiter #(
        .N_RD         (N_RD),
        .NODE_W       (NODE_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT),
        .TAG_W        (TAG_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bank_agg_mode (bank_agg_mode),
        .rd_req        (rd_req),
        .rd_node_id    (rd_node_id),
        .rd_gnt        (rd_gnt),
        .wb_valid      (wb_valid),
        .wb_node_id    (wb_node_id),
        .wb_data       (wb_data),
        .wb_eos        (wb_eos),
        .wb_ready      (wb_ready),
        .bank_rd_eos   (bank_rd_eos),
        .out_valid     (out_valid),
        .out_rd_wr     (out_rd_wr),
        .out_node_id   (out_node_id),
        .out_data      (out_data),
        .out_wr_eos    (out_wr_eos),
        .out_pe_tag    (out_pe_tag),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Inputs change just after the falling edge; outputs are sampled 1 ns later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bank_agg_mode = 1'b1;
        rd_req        = '0;
        rd_node_id    = '0;
        wb_valid      = 1'b0;
        wb_node_id    = '0;
        wb_data       = '0;
        wb_eos        = 1'b0;
        bank_rd_eos   = 1'b0;
    endtask

    task automatic do_reset();
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step();
        idle_inputs();
        reset    = 1'b1;
        rd_req   = 4'b1111;
        wb_valid = 1'b1;
        #1;
        checks++;
        if ({rd_gnt, out_valid, out_rd_wr, out_wr_eos, wb_ready, busy, out_pe_tag, out_node_id, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_asserted gnt=%b valid=%b ready=%b busy=%b required all 0", rd_gnt, out_valid, wb_ready, busy);
        end
        step();
        idle_inputs();
        reset = 1'b0;
        #1;
        checks++;
        if ({rd_gnt, out_valid, out_rd_wr, out_wr_eos, wb_ready, busy, out_pe_tag, out_node_id, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_state gnt=%b valid=%b ready=%b busy=%b node=%0d required all 0", rd_gnt, out_valid, wb_ready, busy, out_node_id);
        end
        $display("reset: outputs idle");
    endtask

    task automatic test_single_read();
        do_reset();
        rd_node_id[1*NODE_W +: NODE_W] = 10'd37;
        rd_req = 4'b0010;
        #1;
        checks++;
        if ({rd_gnt, out_valid, out_rd_wr, out_wr_eos, out_node_id, out_pe_tag, busy} !== {4'b0010, 1'b1, 1'b0, 1'b0, 10'd37, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL single_read_grant gnt=%b valid=%b rdwr=%b node=%0d tag=%0d required 0010 1 0 37 1", rd_gnt, out_valid, out_rd_wr, out_node_id, out_pe_tag);
        end
        for (int c = 0; c < 2; c++) begin
            step();
            rd_req = '0;
            rd_node_id[1*NODE_W +: NODE_W] = 10'd99;
            #1;
            checks++;
            if ({rd_gnt, out_valid, out_node_id, out_pe_tag, busy} !== {4'b0000, 1'b0, 10'd37, 2'd1, 1'b1}) begin
                errors++;
                $display("FAIL single_read_hold gnt=%b valid=%b node=%0d tag=%0d busy=%b required 0000 0 37 1 1", rd_gnt, out_valid, out_node_id, out_pe_tag, busy);
            end
        end
        step();
        bank_rd_eos = 1'b1;
        #1;
        checks++;
        if ({busy, out_node_id} !== {1'b1, 10'd37}) begin
            errors++;
            $display("FAIL single_read_eos busy=%b node=%0d required 1 37", busy, out_node_id);
        end
        step();
        bank_rd_eos = 1'b0;
        #1;
        checks++;
        if ({busy, out_valid, out_node_id} !== '0) begin
            errors++;
            $display("FAIL single_read_done busy=%b valid=%b node=%0d required 0 0 0", busy, out_valid, out_node_id);
        end
        $display("single read: pe=1 node=37");
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        do_reset();
        for (int i = 0; i < N_RD; i++) rd_node_id[i*NODE_W +: NODE_W] = NODE_W'(20 + i);
        rd_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            eg = 4'b0001 << (k % 4);
            #1;
            checks++;
            if ({rd_gnt, out_valid, out_pe_tag, out_node_id} !== {eg, 1'b1, TAG_W'(k % 4), NODE_W'(20 + k % 4)}) begin
                errors++;
                $display("FAIL rr_grant_%0d gnt=%b tag=%0d node=%0d required %b %0d %0d", k, rd_gnt, out_pe_tag, out_node_id, eg, k % 4, 20 + k % 4);
            end
            $display("round robin grant %0d: pe=%0d", k, out_pe_tag);
            step();
            step();
            step();
            bank_rd_eos = 1'b1;
            step();
            bank_rd_eos = 1'b0;
        end
    endtask

    task automatic test_wr_burst();
        do_reset();
        wb_node_id = 10'd12;
        for (int b = 0; b < 8; b++) begin
            if (b > 0) step();
            wb_valid = 1'b1;
            wb_data  = DATA_W'(100 + b);
            wb_eos   = (b == 7);
            #1;
            checks++;
            if ({out_valid, out_rd_wr, wb_ready, out_wr_eos, out_node_id, busy, out_data} !==
                {1'b1, 1'b1, 1'b1, (b == 7), 10'd12, (b != 0), DATA_W'(100 + b)}) begin
                errors++;
                $display("FAIL wr_beat_%0d valid=%b rdwr=%b ready=%b eos=%b node=%0d busy=%b data=%0d required 1 1 1 %0d 12 %0d %0d",
                         b, out_valid, out_rd_wr, wb_ready, out_wr_eos, out_node_id, busy, out_data, (b == 7), (b != 0), 100 + b);
            end
        end
        step();
        wb_valid = 1'b0;
        wb_eos   = 1'b0;
        #1;
        checks++;
        if ({busy, out_valid, wb_ready} !== 3'b000) begin
            errors++;
            $display("FAIL wr_burst_done busy=%b valid=%b ready=%b required 000", busy, out_valid, wb_ready);
        end
        $display("write burst: node=12 beats=8");
    endtask

    task automatic test_starvation();
        do_reset();
        rd_node_id[0 +: NODE_W] = 10'd5;
        rd_req     = 4'b0001;
        wb_valid   = 1'b1;
        wb_eos     = 1'b1;
        wb_node_id = 10'd7;
        wb_data    = DATA_W'(55);
        for (int k = 0; k < STARVE_LIMIT; k++) begin
            if (k > 0) step();
            #1;
            checks++;
            if ({rd_gnt, out_valid, out_rd_wr, wb_ready, out_wr_eos, out_node_id} !== {4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 10'd7}) begin
                errors++;
                $display("FAIL starve_write_%0d gnt=%b valid=%b rdwr=%b ready=%b node=%0d required 0000 1 1 1 7", k, rd_gnt, out_valid, out_rd_wr, wb_ready, out_node_id);
            end
        end
        step();
        #1;
        checks++;
        if ({rd_gnt, out_valid, out_rd_wr, wb_ready, out_wr_eos, out_node_id, out_pe_tag} !== {4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 10'd5, 2'd0}) begin
            errors++;
            $display("FAIL starve_read_wins gnt=%b valid=%b rdwr=%b ready=%b node=%0d required 0001 1 0 0 5", rd_gnt, out_valid, out_rd_wr, wb_ready, out_node_id);
        end
        step();
        rd_req = '0;
        #1;
        checks++;
        if ({busy, out_valid, wb_ready} !== 3'b100) begin
            errors++;
            $display("FAIL starve_rd_wait busy=%b valid=%b ready=%b required 1 0 0", busy, out_valid, wb_ready);
        end
        step();
        bank_rd_eos = 1'b1;
        step();
        bank_rd_eos = 1'b0;
        rd_req      = 4'b0001;
        #1;
        checks++;
        if ({rd_gnt, out_rd_wr, wb_ready} !== {4'b0000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL starve_count_cleared gnt=%b rdwr=%b ready=%b required 0000 1 1", rd_gnt, out_rd_wr, wb_ready);
        end
        step();
        rd_req   = '0;
        wb_valid = 1'b0;
        $display("starvation: %0d writes then pe0", STARVE_LIMIT);
    endtask

    task automatic test_mode_gating();
        do_reset();
        bank_agg_mode = 1'b0;
        for (int i = 0; i < N_RD; i++) rd_node_id[i*NODE_W +: NODE_W] = NODE_W'(20 + i);
        rd_req   = 4'b1111;
        wb_valid = 1'b1;
        wb_eos   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step();
            #1;
            checks++;
            if ({rd_gnt, out_valid, wb_ready, busy} !== 7'b0) begin
                errors++;
                $display("FAIL mode_off_cycle_%0d gnt=%b valid=%b ready=%b busy=%b required 0", c, rd_gnt, out_valid, wb_ready, busy);
            end
        end
        step();
        bank_agg_mode = 1'b1;
        wb_valid      = 1'b0;
        #1;
        checks++;
        if ({rd_gnt, out_valid, out_node_id} !== {4'b0001, 1'b1, 10'd20}) begin
            errors++;
            $display("FAIL mode_on_grant gnt=%b valid=%b node=%0d required 0001 1 20", rd_gnt, out_valid, out_node_id);
        end
        step();
        bank_agg_mode = 1'b0;
        rd_req        = 4'b1110;
        #1;
        checks++;
        if ({busy, rd_gnt, out_node_id} !== {1'b1, 4'b0000, 10'd20}) begin
            errors++;
            $display("FAIL mode_drop_mid_read busy=%b gnt=%b node=%0d required 1 0000 20", busy, rd_gnt, out_node_id);
        end
        step();
        bank_rd_eos = 1'b1;
        step();
        bank_rd_eos = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) step();
            #1;
            checks++;
            if ({rd_gnt, out_valid, wb_ready, busy} !== 7'b0) begin
                errors++;
                $display("FAIL mode_off_after_read_%0d gnt=%b valid=%b busy=%b required 0", c, rd_gnt, out_valid, busy);
            end
        end
        $display("mode gating: one read granted, none while mode low");
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        rd_node_id[2*NODE_W +: NODE_W] = 10'd3;
        rd_req = 4'b0100;
        #1;
        checks++;
        if (rd_gnt !== 4'b0100) begin
            errors++;
            $display("FAIL pre_burst_read gnt=%b required 0100", rd_gnt);
        end
        step();
        rd_req      = '0;
        bank_rd_eos = 1'b1;
        step();
        bank_rd_eos = 1'b0;
        wb_node_id  = 10'd12;
        for (int b = 0; b < 3; b++) begin
            if (b > 0) step();
            wb_valid = 1'b1;
            wb_data  = DATA_W'(200 + b);
            #1;
            checks++;
            if ({out_valid, out_rd_wr, out_data} !== {1'b1, 1'b1, DATA_W'(200 + b)}) begin
                errors++;
                $display("FAIL mid_burst_beat_%0d valid=%b rdwr=%b data=%0d required 1 1 %0d", b, out_valid, out_rd_wr, out_data, 200 + b);
            end
        end
        step();
        wb_data = DATA_W'(203);
        reset   = 1'b1;
        step();
        idle_inputs();
        reset = 1'b0;
        #1;
        checks++;
        if ({rd_gnt, out_valid, out_rd_wr, out_wr_eos, wb_ready, busy, out_pe_tag, out_node_id, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_mid_burst gnt=%b valid=%b ready=%b busy=%b required all 0", rd_gnt, out_valid, wb_ready, busy);
        end
        step();
        rd_req = 4'b1111;
        #1;
        checks++;
        if ({rd_gnt, out_pe_tag} !== {4'b0001, 2'd0}) begin
            errors++;
            $display("FAIL reset_rr_ptr gnt=%b tag=%0d required 0001 0", rd_gnt, out_pe_tag);
        end
        $display("reset mid burst: idle, pointer back to pe0");
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_wr_burst();
        test_starvation();
        test_mode_gating();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
